// File: rtl/scalar_product_seq.sv
// Sequential dot product of Ndata unsigned element pairs, one pair per accept,
// with a valid/ready result port and a synchronous clear.
module scalar_product_seq #(
  parameter int unsigned Nbits = 4,
  parameter int unsigned Ndata = 3,
  localparam int unsigned CntW = $clog2(Ndata + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Nbits-1:0]     in_a,
  input  logic [Nbits-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*Nbits-1:0]   out_data,
  output logic [CntW-1:0]      elem_cnt
);

  typedef enum logic [0:0] {StAcc, StDone} state_e;

  localparam logic [CntW-1:0] LastIdx = CntW'(Ndata - 1);

  state_e                state_q, state_d;
  logic [2*Nbits-1:0]    acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2*Nbits-1:0]    prod;

  // Single shared multiplier, zero-extended so the product keeps full width.
  assign prod = {{Nbits{1'b0}}, in_a} * {{Nbits{1'b0}}, in_b};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (clear) begin
      // Clear wins over any concurrent handshake.
      state_d = StAcc;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (in_valid) begin
            acc_d = acc_q + prod;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastIdx) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_d = StAcc;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StAcc;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Handshake outputs depend only on registered state.
  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StDone);
  assign out_data  = acc_q;
  assign elem_cnt  = cnt_q;

endmodule

// File: tb/tb_scalar_product_seq.sv
// Self-checking bench for scalar_product_seq (Nbits=4, Ndata=3) with a
// queue scoreboard of expected dot products.
module tb_scalar_product_seq;

  logic       clk = 1'b0;
  logic       resetn;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] elem_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model_acc = '0;
  int         model_cnt = 0;
  logic [7:0] exp_v;

  scalar_product_seq #(.Nbits(4), .Ndata(3)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .elem_cnt (elem_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    model_acc = '0;
    model_cnt = 0;
  endtask

  // Present one pair for one cycle; the model assumes the block is in ACC.
  task automatic feed(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
    model_acc = 8'(int'(model_acc) + int'(a) * int'(b));
    model_cnt++;
    if (model_cnt == 3) begin
      exp_q.push_back(model_acc);
      model_reset();
    end
  endtask

  task automatic wait_out();
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) step();
  endtask

  task automatic test_reset();
    resetn = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    #2;
    n_cmp++;
    if ({in_ready, out_valid, out_data, elem_cnt} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b vld=%b data=%h cnt=%0d, need 1 0 00 0",
               in_ready, out_valid, out_data, elem_cnt);
    end
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    feed(4'd1, 4'd4);
    feed(4'd2, 4'd5);
    feed(4'd3, 4'd6);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_v) begin
      n_fail++;
      $display("FAIL basic_out: got vld=%b rdy=%b data=%h, need 1 0 %h",
               out_valid, in_ready, out_data, exp_v);
    end
    n_cmp++;
    if (elem_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL basic_cnt: got %0d, need 3", elem_cnt);
    end
    step();
    n_cmp++;
    if ({in_ready, out_valid, out_data, elem_cnt} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL basic_after: got rdy=%b vld=%b data=%h cnt=%0d, need 1 0 00 0",
               in_ready, out_valid, out_data, elem_cnt);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b1;
    repeat (3) feed(4'd15, 4'd15);
    wait_out();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== exp_v) begin
      n_fail++;
      $display("FAIL overflow: got vld=%b data=%h, need 1 %h", out_valid, out_data, exp_v);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    repeat (3) feed(4'd1, 4'd1);
    exp_v = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 4'd5; in_b = 4'd5;
      n_cmp++;
      if ({out_valid, in_ready, out_data, elem_cnt} !== {1'b1, 1'b0, exp_v, 2'd3}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b data=%h cnt=%0d, need 1 0 %h 3",
                 i, out_valid, in_ready, out_data, elem_cnt, exp_v);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    n_cmp++;
    if ({in_ready, out_valid, out_data, elem_cnt} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL backpressure_release: got rdy=%b vld=%b data=%h cnt=%0d, need 1 0 00 0",
               in_ready, out_valid, out_data, elem_cnt);
    end
  endtask

  task automatic test_bubbles();
    logic [3:0] as[3];
    logic [3:0] bs[3];
    as = '{4'd2, 4'd4, 4'd1};
    bs = '{4'd3, 4'd4, 4'd7};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      feed(as[i], bs[i]);
      if (i < 2) begin
        out_ready = 1'b1;  // no effect in ACC
        repeat (2) step();
        out_ready = 1'b0;
        n_cmp++;
        if (elem_cnt !== 2'(i + 1) || out_data !== model_acc) begin
          n_fail++;
          $display("FAIL bubble[%0d]: got cnt=%0d data=%h, need %0d %h",
                   i, elem_cnt, out_data, i + 1, model_acc);
        end
      end
    end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== exp_v) begin
      n_fail++;
      $display("FAIL bubbles_out: got vld=%b data=%h, need 1 %h", out_valid, out_data, exp_v);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    feed(4'd7, 4'd7);
    feed(4'd7, 4'd7);
    n_cmp++;
    if (elem_cnt !== 2'd2 || out_data !== 8'd98) begin
      n_fail++;
      $display("FAIL clear_pre: got cnt=%0d data=%h, need 2 62", elem_cnt, out_data);
    end
    // Clear together with a third pair: the pair must be discarded.
    clear = 1'b1; in_valid = 1'b1; in_a = 4'd3; in_b = 4'd3;
    step();
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    n_cmp++;
    if ({in_ready, out_valid, out_data, elem_cnt} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL clear_acc: got rdy=%b vld=%b data=%h cnt=%0d, need 1 0 00 0",
               in_ready, out_valid, out_data, elem_cnt);
    end
    out_ready = 1'b0;
    repeat (3) feed(4'd1, 4'd1);
    wait_out();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== exp_v) begin
      n_fail++;
      $display("FAIL clear_next: got vld=%b data=%h, need 1 %h", out_valid, out_data, exp_v);
    end
    clear = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, out_data, elem_cnt} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL clear_done: got rdy=%b vld=%b data=%h cnt=%0d, need 1 0 00 0",
               in_ready, out_valid, out_data, elem_cnt);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    feed(4'd3, 4'd3);
    n_cmp++;
    if (elem_cnt !== 2'd1 || out_data !== model_acc) begin
      n_fail++;
      $display("FAIL areset_pre: got cnt=%0d data=%h, need 1 %h", elem_cnt, out_data, model_acc);
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_data, elem_cnt} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
      n_fail++;
      $display("FAIL areset_now: got rdy=%b vld=%b data=%h cnt=%0d, need 1 0 00 0",
               in_ready, out_valid, out_data, elem_cnt);
    end
    resetn = 1'b1;
    model_reset();
    step();
    repeat (3) feed(4'd2, 4'd2);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== exp_v) begin
      n_fail++;
      $display("FAIL areset_next: got vld=%b data=%h, need 1 %h", out_valid, out_data, exp_v);
    end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      repeat (3) feed(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp_v) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got vld=%b data=%h, need 1 %h", v, out_valid, out_data, exp_v);
      end
      step();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: got %0d entries, need 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_bubbles();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/scalar_product_seq.md
SCALAR_PRODUCT_SEQ -- requirements
Module: scalar_product_seq

Interface
REQ-001 SHALL have parameter Nbits, default 4: width of one unsigned vector element.
REQ-002 SHALL have parameter Ndata, default 3 (>=2): number of element pairs per dot product.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port clear, input, 1: synchronous abort of the current accumulation.
REQ-006 SHALL have port in_valid, input, 1: element pair on in_a/in_b is valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts an element pair this cycle.
REQ-008 SHALL have port in_a, input, Nbits: element a_i, unsigned.
REQ-009 SHALL have port in_b, input, Nbits: element b_i, unsigned.
REQ-010 SHALL have port out_valid, output, 1: out_data holds a completed dot product.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts out_data this cycle.
REQ-012 SHALL have port out_data, output, 2*Nbits: sum of a_i*b_i, i=0..Ndata-1, modulo 2^(2*Nbits).
REQ-013 SHALL have port elem_cnt, output, clog2(Ndata+1): number of pairs accepted in the current vector.

Function
REQ-014 SHALL implement FSM with two states: ACC (collecting pairs) and DONE (result held).
REQ-015 In ACC: in_ready=1 and out_valid=0; in DONE: in_ready=0 and out_valid=1.
REQ-016 SHALL accept an input pair only on a cycle with in_valid=1 and in_ready=1.
REQ-017 Each accepted pair SHALL update acc <= acc + in_a*in_b; the product is full 2*Nbits width, and the sum wraps modulo 2^(2*Nbits) with no saturation or overflow flag.
REQ-018 Each accepted pair SHALL increment elem_cnt by 1.
REQ-019 Acceptance of pair number Ndata SHALL move the FSM ACC->DONE on the same edge; out_valid=1 and out_data=final sum appear in the next cycle (latency 1 cycle from last accept).
REQ-020 In DONE, out_data SHALL be held stable, and no pair shall be accepted, until out_valid=1 and out_ready=1 are both sampled.
REQ-021 The output handshake SHALL move DONE->ACC and set acc=0 and elem_cnt=0; in_ready returns to 1 in the following cycle.
REQ-022 in_valid=0 cycles (bubbles) in ACC SHALL leave acc and elem_cnt unchanged.
REQ-023 out_data SHALL equal acc at all times, and SHALL be 0 whenever elem_cnt=0 in ACC.
REQ-024 clear=1 SHALL, on the next edge, force ACC with acc=0 and elem_cnt=0 from either state.
REQ-025 clear SHALL take priority over a simultaneous input or output handshake; the concurrent pair is discarded and any pending result is dropped.
REQ-026 out_ready and in_valid asserted while not applicable (out_ready in ACC, in_valid in DONE) SHALL have no effect.
REQ-027 The datapath SHALL contain exactly one Nbits x Nbits multiplier, reused each accept; no combinational path from in_valid to in_ready, or from out_ready to out_valid, is permitted.

Reset
REQ-028 resetn=0 SHALL immediately, without waiting for clk, force state=ACC, acc=0, elem_cnt=0, in_ready=1, out_valid=0, out_data=0.
REQ-029 Reset asserted mid-vector or in DONE SHALL discard all partial and pending results; after release, the first accepted pair is element 0.

Verification
REQ-030 Nbits=4, Ndata=3; pairs (1,4),(2,5),(3,6) on consecutive cycles, out_ready=1 -> out_valid=1 one cycle after 3rd accept, out_data=0x20 (32), then in_ready=1 next cycle.
REQ-031 Overflow: three pairs (15,15) -> out_data=0xA3 (675 mod 256).
REQ-032 Backpressure: after (1,1),(1,1),(1,1), hold out_ready=0 for 5 cycles with in_valid=1 -> out_data=0x03 stable, in_ready=0, elem_cnt=3, no extra accept; out_ready=1 -> handshake, next vector starts at acc=0.
REQ-033 Bubbles: pairs (2,3),(4,4),(1,7) separated by 2 idle cycles each -> out_data=0x1D (29).
REQ-034 clear after 2 accepted pairs (7,7),(7,7), then pairs (1,1)x3 -> out_data=0x03; clear asserted in the same cycle as an output handshake -> result dropped, state ACC, elem_cnt=0.
REQ-035 resetn pulsed low between clock edges after 1 accepted pair -> outputs go to reset values immediately; subsequent pairs (2,2)x3 give out_data=0x0C.
